serial_adder: RTL and testbench

Bit-serial N-bit adder. It is the sequential inverse of the team's combinational subtractor: given a difference and a subtrahend, it recovers the minuend (diff + b). One operand bit is processed per clock, LSB first, through a single 1-bit full-adder cell. A start/busy/done handshake lets a controller FSM reuse one cell instead of an N-bit ripple adder.

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 14 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the counter width helper.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Bit-counter width for an n-bit operand; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic cell in the
// serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one bit per clock through one full-adder
// cell. Define SERIAL_ADDER_SUB_EN to add a 'sub' port computing a + ~b + 1.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          last_bit;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-2:0]  sum_sr;
  logic [N-1:0]  sum_next;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_c;
  logic [N-1:0]  b_load;
  logic          c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (cnt == LAST);
  // sum_sr keeps only the N-1 bits already produced; the final bit is
  // appended as the result is committed.
  assign sum_next = {fa_s, sum_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[N-1:1]};
      b_sr   <= {1'b0, b_sr[N-1:1]};
      sum_sr <= sum_next[N-1:1];
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= sum_next;
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized
// operands checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;
  logic [N:0] prev_e;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic; subtraction gives cout = no borrow.
  function automatic logic [N:0] model(input int unsigned ta, input int unsigned tb,
                                       input int unsigned tc, input bit ts);
    int unsigned r;
    if (ts) r = ta + (1 << N) - tb;
    else    r = ta + tb + tc;
    return (N+1)'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic tc, input bit ts);
    logic [N:0] e;
    e = model(ta, tb, tc, ts);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    for (int i = 0; i < N; i++) begin
      check("busy_shift", busy, 1);
      check("done_low_shift", done, 0);
      check("result_held", {cout, sum}, prev_e);
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("result", {cout, sum}, e);
    prev_e = e;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int cycles, last_acc, nacc, ndone;
    logic prev_busy;
    logic [N:0] lat_e;
    logic [N-1:0] cur_a, cur_b;
    logic cur_c;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    prev_e = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;

    // Basic additions and result holding between operations.
    do_op(4'd5, 4'd2, 1'b0, 1'b0);
    check("t1_sum", sum, 4'b0111);
    do_op(4'd15, 4'd1, 1'b0, 1'b0);
    check("t2_cout", cout, 1);
    do_op(4'd3, 4'd3, 1'b1, 1'b0);
    check("t2b_sum", sum, 4'b0111);

    // start during SHIFT and DONE must be ignored.
    @(negedge clk);
    a = 4'd9; b = 4'd4; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = '0; b = '0;
    for (int i = 0; i < N; i++) begin
      check("t3_busy", busy, 1);
      @(negedge clk);
    end
    check("t3_done", done, 1);
    check("t3_result", {cout, sum}, 5'b01101);
    @(negedge clk);
    check("t3_idle_done", done, 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_no_extra_done", done, 0);
      check("t3_no_extra_busy", busy, 0);
      check("t3_sum_kept", sum, 4'b1101);
    end
    prev_e = 5'b01101;

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 4'd7; b = 4'd7; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_sum", sum, 0);
    check("t4_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_e = '0;
    @(negedge clk);
    check("t4_after_busy", busy, 0);
    check("t4_after_done", done, 0);
    do_op(4'd1, 4'd1, 1'b0, 1'b0);
    check("t4_sum_after", sum, 4'b0010);

    // start held high: back-to-back operations N+2 cycles apart.
    cycles = 0; last_acc = 0; nacc = 0; ndone = 0; prev_busy = busy; lat_e = '0;
    @(negedge clk);
    cur_a = 4'hA; cur_b = 4'h5; cur_c = 1'b0;
    a = cur_a; b = cur_b; cin = cur_c; start = 1'b1;
    while (ndone < 6 && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (busy && !prev_busy) begin
        if (nacc > 0) check("b2b_spacing", cycles - last_acc, N + 2);
        last_acc = cycles;
        lat_e = model(cur_a, cur_b, cur_c, 1'b0);
        nacc++;
        if (nacc[0]) begin
          cur_a = N'($urandom); cur_b = N'($urandom); cur_c = 1'b1;
        end else begin
          cur_a = ~cur_a; cur_b = ~cur_b; cur_c = 1'b0;
        end
        a = cur_a; b = cur_b; cin = cur_c;
      end
      if (done) begin
        check("b2b_result", {cout, sum}, lat_e);
        ndone++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 6);
    prev_e = lat_e;
    for (int i = 0; i < N + 2; i++) @(negedge clk);
    check("b2b_drained", busy, 0);

    // Randomized additions.
    for (int i = 0; i < 10; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    do_op(4'd2, 4'd5, 1'b0, 1'b1);
    check("sub_2_5", {cout, sum}, 5'b01101);
    do_op(4'd5, 4'd2, 1'b0, 1'b1);
    check("sub_5_2", {cout, sum}, 5'b10011);
    do_op(4'd3, 4'd3, 1'b1, 1'b1);
    check("sub_3_3", {cout, sum}, 5'b10000);
    for (int i = 0; i < 8; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
